// File: rtl/sigmoid_act_pkg.sv
// Shared types for the sigmoid_act activation unit: mode encoding, the stage-1
// per-lane record and clip-flag classification.
package sigmoid_pkg;

  // Widest stage-1 offset value supported; lanes with WI up to 32 fit here.
  localparam int SIG_T_W = 33;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_HSIG = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e                     mode;
    logic                      sign;
    logic signed [SIG_T_W-1:0] t;
  } s1_t;

  typedef enum logic [1:0] {
    CLIP_NONE = 2'b00,
    CLIP_LO   = 2'b01,
    CLIP_HI   = 2'b10
  } clip_e;

  function automatic logic is_clip(input clip_e c);
    logic r;
    case (c)
      CLIP_LO, CLIP_HI: r = 1'b1;
      CLIP_NONE:        r = 1'b0;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_act_if.sv
// Sample-in / activation-out handshake bundle of sigmoid_act.
interface sigmoid_act_if #(
  parameter int NCH = 4,
  parameter int WI  = 16,
  parameter int WO  = 4
);
  logic                i_valid;
  logic                i_ready;
  logic                i_mode;
  logic [NCH*WI-1:0]   i_tdata;
  logic                o_valid;
  logic                o_ready;
  logic [NCH*WO-1:0]   o_tdata;

  modport master (
    output i_valid, i_mode, i_tdata, o_ready,
    input  i_ready, o_valid, o_tdata
  );

  modport slave (
    input  i_valid, i_mode, i_tdata, o_ready,
    output i_ready, o_valid, o_tdata
  );
endinterface

// File: rtl/sigmoid_act_lane.sv
// One channel of sigmoid_act: stage-1 shift/offset, stage-2 clamp and quantise.
// With SIGMOID_ACT_SAT_CNT_EN defined the lane also registers a clip flag.
module sigmoid_lane
  import sigmoid_pkg::*;
#(
  parameter int WI   = 16,
  parameter int FRAC = 8,
  parameter int WO   = 4
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          en,
  input  logic          mode,
  input  logic [WI-1:0] x,
  output logic [WO-1:0] q
`ifdef SIGMOID_ACT_SAT_CNT_EN
  ,
  output logic          clip
`endif
);

  localparam logic signed [WI:0]    HALF_C  = (WI+1)'(1'b1) << (FRAC-1);
  localparam logic [SIG_T_W-1:0]    T_ONE_C = SIG_T_W'(1'b1) << FRAC;

  logic signed [WI:0] x_ext_s;
  logic signed [WI:0] t_s;
  s1_t                s1_nxt_s;
  s1_t                s1_r;
  logic               t_lo_s;
  logic               t_hi_s;
  logic [WO-1:0]      q_nxt_s;
  logic [WO-1:0]      q_r;

  assign x_ext_s = {x[WI-1], x};
  assign t_s     = (x_ext_s >>> 2'd2) + HALF_C;

  // Stage-1 record for this lane
  always_comb begin
    s1_nxt_s      = '0;
    s1_nxt_s.mode = mode_e'(mode);
    s1_nxt_s.sign = x[WI-1];
    s1_nxt_s.t    = SIG_T_W'(t_s);
  end

  // Stage-1 register
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_r <= '0;
    end else if (en) begin
      s1_r <= s1_nxt_s;
    end
  end

  // A negative t wins over the unsigned high-range compare below.
  assign t_lo_s = s1_r.t[SIG_T_W-1];
  assign t_hi_s = ($unsigned(s1_r.t) >= T_ONE_C);

  // Stage-2 clamp / quantise
  always_comb begin
    q_nxt_s = '0;
    if (s1_r.mode == MODE_STEP) begin
      q_nxt_s = s1_r.sign ? '0 : '1;
    end else if (t_lo_s) begin
      q_nxt_s = '0;
    end else if (t_hi_s) begin
      q_nxt_s = '1;
    end else begin
      q_nxt_s = s1_r.t[FRAC-1 -: WO];
    end
  end

  // Stage-2 data register
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= q_nxt_s;
    end
  end

  assign q = q_r;

`ifdef SIGMOID_ACT_SAT_CNT_EN
  clip_e clip_nxt_s;
  clip_e clip_r;

  // Clip classification; step mode never clips
  always_comb begin
    clip_nxt_s = CLIP_NONE;
    if (s1_r.mode == MODE_STEP) begin
      clip_nxt_s = CLIP_NONE;
    end else if (t_lo_s) begin
      clip_nxt_s = CLIP_LO;
    end else if (t_hi_s) begin
      clip_nxt_s = CLIP_HI;
    end else begin
      clip_nxt_s = CLIP_NONE;
    end
  end

  // Clip flag travels alongside the stage-2 data
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      clip_r <= CLIP_NONE;
    end else if (en) begin
      clip_r <= clip_nxt_s;
    end
  end

  assign clip = is_clip(clip_r);
`endif

endmodule

// File: rtl/sigmoid_act.sv
// Multi-channel step / hard-sigmoid activation with a two-stage valid/ready pipeline.
// Optional saturation counter built when SIGMOID_ACT_SAT_CNT_EN is defined.
module sigmoid_act
  import sigmoid_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int WI   = 16,
  parameter int FRAC = 8,
  parameter int WO   = 4,
  parameter int CW   = 16
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  sigmoid_act_if.slave  bus,
  input  logic          i_cnt_clr,
  output logic [CW-1:0] o_sat_cnt
);

  logic              en_s;
  logic              s1_valid_r;
  logic [NCH*WO-1:0] tdata_s;

  // Both stages advance together whenever the output slot is free or draining.
  assign en_s        = !bus.o_valid || bus.o_ready;
  assign bus.i_ready = en_s;
  assign bus.o_tdata = tdata_s;

  // Valid pipeline
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_r  <= 1'b0;
      bus.o_valid <= 1'b0;
    end else if (en_s) begin
      s1_valid_r  <= bus.i_valid;
      bus.o_valid <= s1_valid_r;
    end
  end

`ifdef SIGMOID_ACT_SAT_CNT_EN
  localparam int PW = $clog2(NCH + 1);

  logic [NCH-1:0] clip_s;
  logic [PW-1:0]  pop_s;
  logic [CW:0]    sum_s;
  logic [CW-1:0]  sat_cnt_nxt_s;
  logic [CW-1:0]  sat_cnt_r;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    sigmoid_lane #(
      .WI   (WI),
      .FRAC (FRAC),
      .WO   (WO)
    ) u_lane (
      .i_sclk (i_sclk),
      .i_rstn (i_rstn),
      .en     (en_s),
      .mode   (bus.i_mode),
      .x      (bus.i_tdata[c*WI +: WI]),
      .q      (tdata_s[c*WO +: WO])
`ifdef SIGMOID_ACT_SAT_CNT_EN
      ,
      .clip   (clip_s[c])
`endif
    );
  end

`ifdef SIGMOID_ACT_SAT_CNT_EN
  // Popcount of clipped lanes and saturating counter update
  always_comb begin
    pop_s = '0;
    for (int c = 0; c < NCH; c++) begin
      pop_s = pop_s + PW'(clip_s[c]);
    end
    sum_s         = {1'b0, sat_cnt_r} + (CW+1)'(pop_s);
    sat_cnt_nxt_s = sat_cnt_r;
    if (i_cnt_clr) begin
      sat_cnt_nxt_s = '0;
    end else if (bus.o_valid && bus.o_ready) begin
      if (sum_s[CW]) begin
        sat_cnt_nxt_s = '1;
      end else begin
        sat_cnt_nxt_s = sum_s[CW-1:0];
      end
    end else begin
      sat_cnt_nxt_s = sat_cnt_r;
    end
  end

  // Saturation counter register
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      sat_cnt_r <= '0;
    end else begin
      sat_cnt_r <= sat_cnt_nxt_s;
    end
  end

  assign o_sat_cnt = sat_cnt_r;
`else
  logic unused_clr_s;

  assign unused_clr_s = i_cnt_clr;
  assign o_sat_cnt    = '0;
`endif

endmodule
